// File: rtl/operand_fetch_if.sv
// Decode-side and EX-side handshake bundles for the operand fetch stage.
// A beat moves on a rising edge when valid && ready; valid may not depend on ready.
interface operand_fetch_if #(
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rs1_addr;
  logic [4:0]        in_rs2_addr;
  logic [4:0]        in_rd_addr;
  logic              in_rd_we;
  logic [31:0]       in_pc;
  logic [31:0]       in_imm;
  logic [CTRL_W-1:0] in_ctrl;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_rs1_val;
  logic [31:0]       out_rs2_val;
  logic [31:0]       out_pc;
  logic [31:0]       out_imm;
  logic [CTRL_W-1:0] out_ctrl;
  logic [4:0]        out_rd_addr;
  logic              out_rd_we;

  modport master (
    output in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rd_we, in_pc, in_imm, in_ctrl,
    input  in_ready,
    input  out_valid, out_rs1_val, out_rs2_val, out_pc, out_imm, out_ctrl, out_rd_addr, out_rd_we,
    output out_ready
  );

  modport slave (
    input  in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rd_we, in_pc, in_imm, in_ctrl,
    output in_ready,
    output out_valid, out_rs1_val, out_rs2_val, out_pc, out_imm, out_ctrl, out_rd_addr, out_rd_we,
    input  out_ready
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: register-file read with writeback bypass, RAW stalls driven by
// per-register in-flight counters, and a single registered entry toward EX.
module operand_fetch #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  operand_fetch_if.slave io,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  input  logic        wb_valid,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_rd_data,
  input  logic        flush
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q [32];
  logic [CNT_W-1:0]  cnt_d [32];
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
  logic [31:0]       out_pc_q, out_pc_d, out_imm_q, out_imm_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic [4:0]        out_rd_q, out_rd_d;
  logic              out_we_q, out_we_d;

  logic        wb_hit, rs1_haz, rs2_haz, sat_haz, in_ready, accept, xfer, kill;
  logic [31:0] rs1_val, rs2_val;

  assign rf_rs1_addr = io.in_rs1_addr;
  assign rf_rs2_addr = io.in_rs2_addr;

  always_comb begin
    wb_hit  = wb_valid && wb_we;
    rs1_val = (wb_hit && wb_rd_addr == io.in_rs1_addr && io.in_rs1_addr != 5'd0) ? wb_rd_data : rf_rs1_data;
    rs2_val = (wb_hit && wb_rd_addr == io.in_rs2_addr && io.in_rs2_addr != 5'd0) ? wb_rd_data : rf_rs2_data;
    // A single pending write that retires this cycle is covered by the bypass path.
    rs1_haz = io.in_rs1_addr != 5'd0 && cnt_q[io.in_rs1_addr] != '0 &&
              !(cnt_q[io.in_rs1_addr] == CNT_ONE && wb_hit && wb_rd_addr == io.in_rs1_addr);
    rs2_haz = io.in_rs2_addr != 5'd0 && cnt_q[io.in_rs2_addr] != '0 &&
              !(cnt_q[io.in_rs2_addr] == CNT_ONE && wb_hit && wb_rd_addr == io.in_rs2_addr);
    sat_haz = io.in_rd_we && io.in_rd_addr != 5'd0 && cnt_q[io.in_rd_addr] == CNT_MAX;
    in_ready = !flush && (!out_valid_q || io.out_ready) && !(rs1_haz || rs2_haz || sat_haz);
    accept   = io.in_valid && in_ready;
    xfer     = out_valid_q && io.out_ready;
    kill     = flush && out_valid_q && !io.out_ready;
  end

  always_comb begin
    logic             inc;
    logic [1:0]       dec;
    logic [CNT_W:0]   sum;
    inc = 1'b0;
    dec = 2'd0;
    sum = '0;
    for (int r = 0; r < 32; r++) begin
      inc = accept && io.in_rd_we && io.in_rd_addr == 5'(r);
      dec = {1'b0, wb_valid && wb_rd_addr == 5'(r)} +
            {1'b0, kill && out_we_q && out_rd_q == 5'(r)};
      sum = {1'b0, cnt_q[r]} + (CNT_W+1)'(inc);
      if (r == 0 || sum <= (CNT_W+1)'(dec)) cnt_d[r] = '0;
      else                                 cnt_d[r] = CNT_W'(sum - (CNT_W+1)'(dec));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    out_pc_d    = out_pc_q;
    out_imm_d   = out_imm_q;
    out_ctrl_d  = out_ctrl_q;
    out_rd_d    = out_rd_q;
    out_we_d    = out_we_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_rs1_d   = rs1_val;
      out_rs2_d   = rs2_val;
      out_pc_d    = io.in_pc;
      out_imm_d   = io.in_imm;
      out_ctrl_d  = io.in_ctrl;
      out_rd_d    = io.in_rd_addr;
      out_we_d    = io.in_rd_we;
    end else if (xfer || kill) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
      out_valid_q <= 1'b0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_pc_q    <= '0;
      out_imm_q   <= '0;
      out_ctrl_q  <= '0;
      out_rd_q    <= '0;
      out_we_q    <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      out_valid_q <= out_valid_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_pc_q    <= out_pc_d;
      out_imm_q   <= out_imm_d;
      out_ctrl_q  <= out_ctrl_d;
      out_rd_q    <= out_rd_d;
      out_we_q    <= out_we_d;
    end
  end

  assign io.in_ready    = in_ready;
  assign io.out_valid   = out_valid_q;
  assign io.out_rs1_val = out_rs1_q;
  assign io.out_rs2_val = out_rs2_q;
  assign io.out_pc      = out_pc_q;
  assign io.out_imm     = out_imm_q;
  assign io.out_ctrl    = out_ctrl_q;
  assign io.out_rd_addr = out_rd_q;
  assign io.out_rd_we   = out_we_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: table of operand reads, hand sequences for stalls, hold,
// flush, saturation and reset, plus a randomized backpressure/bypass run.
module tb_operand_fetch;
  localparam int EW = 150;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_valid = 1'b0, wb_we = 1'b0, flush = 1'b0;
  logic [4:0]  wb_rd_addr = '0;
  logic [31:0] wb_rd_data = '0;
  logic [31:0] rf_m [32];

  operand_fetch_if #(.CTRL_W(16)) io ();

  operand_fetch #(.CTRL_W(16), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .io(io),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .flush(flush)
  );

  always #5 clk = ~clk;
  assign rf_rs1_data = rf_m[rf_rs1_addr];
  assign rf_rs2_data = rf_m[rf_rs2_addr];

  logic [EW-1:0] exp_q[$];
  int pass_cnt = 0, total_cnt = 0;
  logic last_ready;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] pc, e1, e2;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [EW-1:0] out_bundle();
    return {io.out_rs1_val, io.out_rs2_val, io.out_pc, io.out_imm, io.out_ctrl,
            io.out_rd_addr, io.out_rd_we};
  endfunction

  function automatic logic [31:0] model_op(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (wb_valid && wb_we && wb_rd_addr == rs) return wb_rd_data;
    return rf_m[rs];
  endfunction

  function automatic logic [EW-1:0] model_exp();
    return {model_op(io.in_rs1_addr), model_op(io.in_rs2_addr), io.in_pc, io.in_imm,
            io.in_ctrl, io.in_rd_addr, io.in_rd_we};
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic [31:0] pc);
    io.in_valid    = v;
    io.in_rs1_addr = rs1;
    io.in_rs2_addr = rs2;
    io.in_rd_addr  = rd;
    io.in_rd_we    = we;
    io.in_pc       = pc;
    io.in_imm      = ~pc;
    io.in_ctrl     = pc[15:0] ^ 16'h5a5a;
  endtask

  task automatic set_wb(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = v; wb_we = we; wb_rd_addr = rd; wb_rd_data = d;
  endtask

  // One clock: observe at the falling edge, then let the rising edge happen.
  task automatic cycle();
    @(negedge clk);
    last_ready = io.in_ready;
    if (io.out_valid && io.out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected: got output %h with empty expected queue", out_bundle());
      end else begin
        check("sb_out", out_bundle(), exp_q.pop_front());
      end
    end else if (flush && io.out_valid && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    if (io.in_valid && io.in_ready) exp_q.push_back(model_exp());
    @(posedge clk);
    #1;
    if (wb_valid && wb_we && wb_rd_addr != 5'd0) rf_m[wb_rd_addr] = wb_rd_data;
  endtask

  task automatic drain();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    set_wb(1'b0, 1'b0, 5'd0, 32'd0);
    flush = 1'b0;
    io.out_ready = 1'b1;
    for (int k = 0; k < 12 && (io.out_valid || exp_q.size() != 0); k++) cycle();
    check("drain_queue", EW'(exp_q.size()), '0);
    check("drain_valid", EW'(io.out_valid), '0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_m[i] = 32'hA000_0000 | 32'(i);
    rf_m[0] = 32'd0;
    rf_m[5] = 32'h0000_1234;
    vecs[0] = '{5'd5,  5'd0,  32'h100, 32'h0000_1234, 32'h0000_0000};
    vecs[1] = '{5'd1,  5'd2,  32'h104, 32'hA000_0001, 32'hA000_0002};
    vecs[2] = '{5'd31, 5'd17, 32'h108, 32'hA000_001F, 32'hA000_0011};
    vecs[3] = '{5'd0,  5'd5,  32'h10C, 32'h0000_0000, 32'h0000_1234};
    vecs[4] = '{5'd12, 5'd12, 32'h110, 32'hA000_000C, 32'hA000_000C};
    vecs[5] = '{5'd30, 5'd1,  32'h114, 32'hA000_001E, 32'hA000_0001};

    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    io.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", EW'(io.out_valid), '0);
    check("reset_data", out_bundle(), '0);
    rst_n = 1'b1;
    cycle();
    check("idle_ready", EW'(last_ready), EW'(1'b1));

    // Plain operand reads with EX always ready.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].rs1, vecs[i].rs2, 5'd20, 1'b0, vecs[i].pc);
      cycle();
      check("vec_ready", EW'(last_ready), EW'(1'b1));
      check("vec_ops", EW'({io.out_valid, io.out_rs1_val, io.out_rs2_val, io.out_pc}),
            EW'({1'b1, vecs[i].e1, vecs[i].e2, vecs[i].pc}));
    end
    drain();

    // RAW stall on x7 released by the same-cycle writeback.
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 32'h200);
    cycle();
    check("raw_issue", EW'(last_ready), EW'(1'b1));
    drive(1'b1, 5'd7, 5'd0, 5'd8, 1'b0, 32'h204);
    repeat (2) begin
      cycle();
      check("raw_stall", EW'(last_ready), '0);
    end
    set_wb(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF);
    cycle();
    check("raw_release", EW'(last_ready), EW'(1'b1));
    set_wb(1'b0, 1'b0, 5'd0, 32'd0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    check("raw_bypass", EW'({io.out_valid, io.out_rs1_val}), EW'({1'b1, 32'hDEAD_BEEF}));
    drain();

    // Backpressure: held entry stays put and blocks the next one.
    io.out_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 5'd4, 1'b0, 32'h400);
    cycle();
    drive(1'b1, 5'd3, 5'd4, 5'd6, 1'b0, 32'h404);
    repeat (3) begin
      cycle();
      check("hold_ready", EW'(last_ready), '0);
      check("hold_data", EW'({io.out_valid, io.out_rs1_val, io.out_rs2_val, io.out_pc}),
            EW'({1'b1, 32'hA000_0001, 32'hA000_0002, 32'h400}));
    end
    io.out_ready = 1'b1;
    cycle();
    check("hold_release", EW'(last_ready), EW'(1'b1));
    drain();

    // Flush kills a held writer of x3; a reader of x3 then issues freely.
    io.out_ready = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 32'h500);
    cycle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    flush = 1'b1;
    cycle();
    check("flush_ready", EW'(last_ready), '0);
    flush = 1'b0;
    check("flush_kill", EW'(io.out_valid), '0);
    io.out_ready = 1'b1;
    drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 32'h504);
    cycle();
    check("flush_nostall", EW'(last_ready), EW'(1'b1));
    drain();

    // Counter saturation on x9 at three pending writes.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h600 + 32'(4 * k));
      cycle();
      check("sat_fill", EW'(last_ready), EW'(1'b1));
    end
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h60C);
    repeat (2) begin
      cycle();
      check("sat_stall", EW'(last_ready), '0);
    end
    set_wb(1'b1, 1'b1, 5'd9, 32'h0000_0099);
    cycle();
    check("sat_wb_cycle", EW'(last_ready), '0);
    set_wb(1'b0, 1'b0, 5'd0, 32'd0);
    cycle();
    check("sat_release", EW'(last_ready), EW'(1'b1));
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    set_wb(1'b1, 1'b0, 5'd9, 32'd0);
    repeat (3) cycle();
    set_wb(1'b0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'h700 + 32'(4 * k));
      cycle();
      check("x0_nostall", EW'(last_ready), EW'(1'b1));
    end
    drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 32'h720);
    cycle();
    check("sat_drained", EW'(last_ready), EW'(1'b1));
    drain();

    // Random reads, writebacks, backpressure and flushes.
    for (int k = 0; k < 60; k++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 1'b0, 32'($urandom));
      io.out_ready = 1'($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      set_wb(1'($urandom_range(0, 1)), 1'b1, 5'($urandom_range(1, 31)), 32'($urandom));
      cycle();
    end
    drain();

    // Asynchronous reset with a held writer of x11 in flight.
    io.out_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd0, 5'd11, 1'b1, 32'h800);
    cycle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", EW'(io.out_valid), '0);
    check("arst_data", out_bundle(), '0);
    exp_q.delete();
    repeat (2) cycle();
    rst_n = 1'b1;
    io.out_ready = 1'b1;
    cycle();
    check("arst_idle_ready", EW'(last_ready), EW'(1'b1));
    drive(1'b1, 5'd11, 5'd0, 5'd0, 1'b0, 32'h804);
    cycle();
    check("arst_cnt_clear", EW'(last_ready), EW'(1'b1));
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
